// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller for the 5-stage RV core.
// Handles load-use, early-branch operand and data-memory-wait hazards.
// A registered scoreboard tracks the destinations of in-flight mul/div ops.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS        = 32,
  parameter int REG_AW          = 5,
  parameter int MAX_MD_INFLIGHT = 2,
  parameter int CNT_W           = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_AW-1:0]   d_rs1,
  input  logic [REG_AW-1:0]   d_rs2,
  input  logic [REG_AW-1:0]   d_rd,
  input  logic                d_use_rs1,
  input  logic                d_use_rs2,
  input  logic                d_we,
  input  logic                d_need_rs_early,
  input  logic                d_is_md,
  input  logic [REG_AW-1:0]   e_rs1,
  input  logic [REG_AW-1:0]   e_rs2,
  input  logic [REG_AW-1:0]   e_rd,
  input  logic                e_we,
  input  logic                e_load,
  input  logic                e_md_issue,
  input  logic [REG_AW-1:0]   m_rd,
  input  logic                m_we,
  input  logic                m_load,
  input  logic [REG_AW-1:0]   w_rd,
  input  logic                w_we,
  input  logic                md_done,
  input  logic [REG_AW-1:0]   md_rd,
  input  logic                dmem_stall,
  input  logic                bj_taken,
  output logic                stall_fetch,
  output logic                stall_decode,
  output logic                flush_decode,
  output logic                stall_execute,
  output logic                flush_execute,
  output logic                stall_memory,
  output logic                flush_memory,
  output logic                flush_writeback,
  output logic [1:0]          fwd_rs1_d,
  output logic [1:0]          fwd_rs2_d,
  output logic [1:0]          fwd_rs1_e,
  output logic [1:0]          fwd_rs2_e,
  output logic [CNT_W-1:0]    md_inflight,
  output logic [NUM_REGS-1:0] sb_pending
);

  localparam int REG_SPAN = 2 ** REG_AW;

  logic [NUM_REGS-1:0] sb_pending_q, sb_pending_d;
  logic [CNT_W-1:0]    md_inflight_q, md_inflight_d;
  logic [REG_SPAN-1:0] pend_ext;
  logic                d_v1, d_v2;
  logic                ld_stall, br_stall, sb_stall, md_full_stall;
  logic                issue_acc, md_dec;

  // Priority: memory stage result, then MD completion, then writeback, else RF.
  function automatic logic [1:0] fwd_sel(
    input logic              valid,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd_i,
    input logic              m_we_i,
    input logic [REG_AW-1:0] md_rd_i,
    input logic              md_done_i,
    input logic [REG_AW-1:0] w_rd_i,
    input logic              w_we_i
  );
    if (valid && m_we_i && rs == m_rd_i)          return 2'b10;
    else if (valid && md_done_i && rs == md_rd_i) return 2'b11;
    else if (valid && w_we_i && rs == w_rd_i)     return 2'b01;
    else                                          return 2'b00;
  endfunction

  // Zero-extend the scoreboard so any REG_AW-wide address can index it.
  always_comb begin
    pend_ext                 = '0;
    pend_ext[NUM_REGS-1:0]   = sb_pending_q;
  end

  // Hazard detection, stall/flush generation and forward selects.
  always_comb begin
    d_v1 = d_use_rs1 && (d_rs1 != '0);
    d_v2 = d_use_rs2 && (d_rs2 != '0);

    ld_stall = e_load && (e_rd != '0) &&
               ((d_v1 && d_rs1 == e_rd) || (d_v2 && d_rs2 == e_rd));

    br_stall = d_need_rs_early &&
               ((d_v1 && ((e_we && d_rs1 == e_rd) || (m_load && d_rs1 == m_rd))) ||
                (d_v2 && ((e_we && d_rs2 == e_rd) || (m_load && d_rs2 == m_rd))));

    // A completing MD op resolves its own RAW hazard via the 11 forward path.
    sb_stall = (d_v1 && pend_ext[d_rs1] && !(md_done && md_rd == d_rs1)) ||
               (d_v2 && pend_ext[d_rs2] && !(md_done && md_rd == d_rs2)) ||
               (d_we && (d_rd != '0) && pend_ext[d_rd]);

    md_full_stall = d_is_md && (md_inflight_q == CNT_W'(MAX_MD_INFLIGHT)) && !md_done;

    stall_execute   = dmem_stall;
    stall_memory    = dmem_stall;
    stall_decode    = ld_stall | br_stall | sb_stall | md_full_stall | dmem_stall;
    stall_fetch     = stall_decode;
    flush_decode    = bj_taken & ~stall_decode;
    flush_execute   = stall_decode & ~dmem_stall;
    flush_memory    = 1'b0;
    flush_writeback = dmem_stall;

    fwd_rs1_d = fwd_sel(d_v1, d_rs1, m_rd, m_we, md_rd, md_done, w_rd, w_we);
    fwd_rs2_d = fwd_sel(d_v2, d_rs2, m_rd, m_we, md_rd, md_done, w_rd, w_we);
    fwd_rs1_e = fwd_sel(e_rs1 != '0, e_rs1, m_rd, m_we, md_rd, md_done, w_rd, w_we);
    fwd_rs2_e = fwd_sel(e_rs2 != '0, e_rs2, m_rd, m_we, md_rd, md_done, w_rd, w_we);
  end

  // Scoreboard and outstanding-count next state; a same-cycle set beats the clear.
  always_comb begin
    issue_acc    = e_md_issue && !dmem_stall;
    md_dec       = md_done && (md_inflight_q != '0);
    sb_pending_d = sb_pending_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (md_done && md_rd == REG_AW'(i))   sb_pending_d[i] = 1'b0;
      if (issue_acc && e_rd == REG_AW'(i))  sb_pending_d[i] = 1'b1;
    end
    sb_pending_d[0] = 1'b0;

    md_inflight_d = md_inflight_q;
    if (issue_acc && !md_dec)      md_inflight_d = md_inflight_q + 1'b1;
    else if (md_dec && !issue_acc) md_inflight_d = md_inflight_q - 1'b1;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_pending_q  <= '0;
      md_inflight_q <= '0;
    end else begin
      sb_pending_q  <= sb_pending_d;
      md_inflight_q <= md_inflight_d;
    end
  end

  assign sb_pending  = sb_pending_q;
  assign md_inflight = md_inflight_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios plus a randomized
// run against a behavioural model of the hazard rules.
module tb_hazard_scoreboard_unit;

  localparam int MAXI = 2;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] d_rs1, d_rs2, d_rd, e_rs1, e_rs2, e_rd, m_rd, w_rd, md_rd;
  logic d_use_rs1, d_use_rs2, d_we, d_need_rs_early, d_is_md;
  logic e_we, e_load, e_md_issue, m_we, m_load, w_we, md_done, dmem_stall, bj_taken;
  logic stall_fetch, stall_decode, flush_decode, stall_execute, flush_execute;
  logic stall_memory, flush_memory, flush_writeback;
  logic [1:0] fwd_rs1_d, fwd_rs2_d, fwd_rs1_e, fwd_rs2_e;
  logic [2:0] md_inflight;
  logic [31:0] sb_pending;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: pending flag per register and outstanding op count.
  bit mpend[32];
  int mcnt;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.NUM_REGS(32), .REG_AW(5), .MAX_MD_INFLIGHT(MAXI), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_we(d_we),
    .d_need_rs_early(d_need_rs_early), .d_is_md(d_is_md),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
    .e_we(e_we), .e_load(e_load), .e_md_issue(e_md_issue),
    .m_rd(m_rd), .m_we(m_we), .m_load(m_load),
    .w_rd(w_rd), .w_we(w_we),
    .md_done(md_done), .md_rd(md_rd),
    .dmem_stall(dmem_stall), .bj_taken(bj_taken),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .flush_decode(flush_decode),
    .stall_execute(stall_execute), .flush_execute(flush_execute),
    .stall_memory(stall_memory), .flush_memory(flush_memory), .flush_writeback(flush_writeback),
    .fwd_rs1_d(fwd_rs1_d), .fwd_rs2_d(fwd_rs2_d), .fwd_rs1_e(fwd_rs1_e), .fwd_rs2_e(fwd_rs2_e),
    .md_inflight(md_inflight), .sb_pending(sb_pending)
  );

  task automatic clear_inputs();
    d_rs1 = 0; d_rs2 = 0; d_rd = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0;
    m_rd = 0; w_rd = 0; md_rd = 0;
    d_use_rs1 = 0; d_use_rs2 = 0; d_we = 0; d_need_rs_early = 0; d_is_md = 0;
    e_we = 0; e_load = 0; e_md_issue = 0; m_we = 0; m_load = 0; w_we = 0;
    md_done = 0; dmem_stall = 0; bj_taken = 0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    e_md_issue = 1; e_rd = 5;
    @(posedge clk); #1;
    clear_inputs();
    n_checks++;
    if (sb_pending !== 32'h20 || md_inflight !== 3'd1) begin
      n_fail++; $display("FAIL reset_pre pending=%h cnt=%0d exp=00000020/1", sb_pending, md_inflight);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (sb_pending !== 32'h0 || md_inflight !== 3'd0) begin
      n_fail++; $display("FAIL reset_async pending=%h cnt=%0d exp=0/0", sb_pending, md_inflight);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    d_use_rs1 = 1; d_rs1 = 5; d_we = 1; d_rd = 5;
    @(negedge clk);
    n_checks++;
    if ({stall_fetch, stall_decode, stall_execute, stall_memory, flush_execute} !== 5'b0) begin
      n_fail++; $display("FAIL reset_stalls got=%b exp=00000",
        {stall_fetch, stall_decode, stall_execute, stall_memory, flush_execute});
    end
  endtask

  task automatic test_md_raw();
    do_reset();
    e_md_issue = 1; e_rd = 5;
    @(posedge clk); #1;
    clear_inputs();
    d_use_rs1 = 1; d_rs1 = 5;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (stall_decode !== 1'b1 || flush_execute !== 1'b1 || sb_pending[5] !== 1'b1) begin
        n_fail++; $display("FAIL md_raw_stall c=%0d sd=%b fe=%b pend5=%b exp=1,1,1",
          c, stall_decode, flush_execute, sb_pending[5]);
      end
      @(posedge clk); #1;
    end
    md_done = 1; md_rd = 5;
    @(negedge clk);
    n_checks++;
    if (fwd_rs1_d !== 2'b11 || stall_decode !== 1'b0) begin
      n_fail++; $display("FAIL md_raw_done fwd=%b sd=%b exp=11,0", fwd_rs1_d, stall_decode);
    end
    @(posedge clk); #1;
    md_done = 0;
    n_checks++;
    if (sb_pending !== 32'h0 || md_inflight !== 3'd0) begin
      n_fail++; $display("FAIL md_raw_after pending=%h cnt=%0d exp=0/0", sb_pending, md_inflight);
    end
  endtask

  task automatic test_md_full();
    do_reset();
    e_md_issue = 1; e_rd = 3;
    @(posedge clk); #1;
    e_rd = 4;
    @(posedge clk); #1;
    clear_inputs();
    d_is_md = 1; d_we = 1; d_rd = 10;
    @(negedge clk);
    n_checks++;
    if (stall_decode !== 1'b1 || md_inflight !== 3'd2) begin
      n_fail++; $display("FAIL md_full_hold sd=%b cnt=%0d exp=1/2", stall_decode, md_inflight);
    end
    @(posedge clk); #1;
    md_done = 1; md_rd = 3;
    @(negedge clk);
    n_checks++;
    if (stall_decode !== 1'b0 || md_inflight !== 3'd2) begin
      n_fail++; $display("FAIL md_full_release sd=%b cnt=%0d exp=0/2", stall_decode, md_inflight);
    end
    @(posedge clk); #1;
    clear_inputs();
    e_md_issue = 1; e_rd = 10;
    n_checks++;
    if (md_inflight !== 3'd1 || sb_pending !== 32'h10) begin
      n_fail++; $display("FAIL md_full_after_done cnt=%0d pending=%h exp=1/00000010", md_inflight, sb_pending);
    end
    @(posedge clk); #1;
    clear_inputs();
    n_checks++;
    if (md_inflight !== 3'd2 || sb_pending !== 32'h410) begin
      n_fail++; $display("FAIL md_full_reissue cnt=%0d pending=%h exp=2/00000410", md_inflight, sb_pending);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    e_md_issue = 1; e_rd = 6;
    @(posedge clk); #1;
    md_done = 1; md_rd = 6;
    @(posedge clk); #1;
    clear_inputs();
    n_checks++;
    if (sb_pending !== 32'h40 || md_inflight !== 3'd1) begin
      n_fail++; $display("FAIL same_cycle_set_clear pending=%h cnt=%0d exp=00000040/1", sb_pending, md_inflight);
    end
    md_done = 1; md_rd = 6;
    @(posedge clk); #1;
    md_done = 1; md_rd = 12;
    @(posedge clk); #1;
    clear_inputs();
    n_checks++;
    if (sb_pending !== 32'h0 || md_inflight !== 3'd0) begin
      n_fail++; $display("FAIL done_at_zero pending=%h cnt=%0d exp=0/0", sb_pending, md_inflight);
    end
  endtask

  task automatic test_load_waw();
    do_reset();
    e_load = 1; e_we = 1; e_rd = 7; d_use_rs1 = 1; d_rs1 = 7;
    @(negedge clk);
    n_checks++;
    if (stall_decode !== 1'b1 || flush_execute !== 1'b1) begin
      n_fail++; $display("FAIL load_use_stall sd=%b fe=%b exp=1,1", stall_decode, flush_execute);
    end
    @(posedge clk); #1;
    e_load = 0; e_we = 0; e_rd = 0; m_rd = 7; m_we = 1; m_load = 1;
    @(negedge clk);
    n_checks++;
    if (stall_decode !== 1'b0 || fwd_rs1_d !== 2'b10) begin
      n_fail++; $display("FAIL load_use_fwd sd=%b fwd=%b exp=0,10", stall_decode, fwd_rs1_d);
    end
    @(posedge clk); #1;
    clear_inputs();
    e_md_issue = 1; e_rd = 9;
    @(posedge clk); #1;
    clear_inputs();
    d_we = 1; d_rd = 9;
    @(negedge clk);
    n_checks++;
    if (stall_decode !== 1'b1 || stall_fetch !== 1'b1) begin
      n_fail++; $display("FAIL waw_stall sd=%b sf=%b exp=1,1", stall_decode, stall_fetch);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_dmem_bj();
    do_reset();
    dmem_stall = 1; bj_taken = 1; e_md_issue = 1; e_rd = 8;
    @(negedge clk);
    n_checks++;
    if ({stall_memory, stall_execute, stall_decode, flush_decode, flush_execute, flush_memory, flush_writeback}
        !== 7'b1110001) begin
      n_fail++; $display("FAIL dmem_bj got=%b exp=1110001",
        {stall_memory, stall_execute, stall_decode, flush_decode, flush_execute, flush_memory, flush_writeback});
    end
    @(posedge clk); #1;
    n_checks++;
    if (sb_pending !== 32'h0 || md_inflight !== 3'd0) begin
      n_fail++; $display("FAIL dmem_no_issue pending=%h cnt=%0d exp=0/0", sb_pending, md_inflight);
    end
    clear_inputs();
    bj_taken = 1;
    @(negedge clk);
    n_checks++;
    if (flush_decode !== 1'b1 || flush_writeback !== 1'b0) begin
      n_fail++; $display("FAIL bj_flush fd=%b fw=%b exp=1,0", flush_decode, flush_writeback);
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  function automatic logic [1:0] m_fwd(bit valid, int rs);
    if (valid && m_we && rs == int'(m_rd))     return 2'b10;
    if (valid && md_done && rs == int'(md_rd)) return 2'b11;
    if (valid && w_we && rs == int'(w_rd))     return 2'b01;
    return 2'b00;
  endfunction

  task automatic test_random();
    bit v1, v2, ld, br, sb, full, sd, acc;
    logic [7:0] exp_ctl, exp_fwd;
    logic [31:0] exp_pend;
    do_reset();
    foreach (mpend[i]) mpend[i] = 0;
    mcnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      d_rs1 = 5'($urandom_range(0, 7)); d_rs2 = 5'($urandom_range(0, 7));
      d_rd  = 5'($urandom_range(0, 7)); e_rs1 = 5'($urandom_range(0, 7));
      e_rs2 = 5'($urandom_range(0, 7)); e_rd  = 5'($urandom_range(0, 7));
      m_rd  = 5'($urandom_range(0, 7)); w_rd  = 5'($urandom_range(0, 7));
      md_rd = 5'($urandom_range(0, 7));
      d_use_rs1 = 1'($urandom); d_use_rs2 = 1'($urandom); d_we = 1'($urandom);
      d_need_rs_early = ($urandom_range(0, 3) == 0); d_is_md = 1'($urandom);
      e_we = 1'($urandom); e_load = ($urandom_range(0, 3) == 0);
      e_md_issue = (mcnt < MAXI) && ($urandom_range(0, 2) == 0);
      m_we = 1'($urandom); m_load = ($urandom_range(0, 3) == 0); w_we = 1'($urandom);
      md_done = ($urandom_range(0, 2) == 0);
      dmem_stall = ($urandom_range(0, 5) == 0); bj_taken = ($urandom_range(0, 3) == 0);

      v1 = d_use_rs1 && d_rs1 != 0;
      v2 = d_use_rs2 && d_rs2 != 0;
      ld = e_load && e_rd != 0 && ((v1 && d_rs1 == e_rd) || (v2 && d_rs2 == e_rd));
      br = d_need_rs_early &&
           ((v1 && ((e_we && d_rs1 == e_rd) || (m_load && d_rs1 == m_rd))) ||
            (v2 && ((e_we && d_rs2 == e_rd) || (m_load && d_rs2 == m_rd))));
      sb = (v1 && mpend[d_rs1] && !(md_done && md_rd == d_rs1)) ||
           (v2 && mpend[d_rs2] && !(md_done && md_rd == d_rs2)) ||
           (d_we && d_rd != 0 && mpend[d_rd]);
      full = d_is_md && mcnt == MAXI && !md_done;
      sd = ld || sb || br || full || dmem_stall;
      exp_ctl = {sd, sd, bj_taken && !sd, dmem_stall, sd && !dmem_stall, dmem_stall, 1'b0, dmem_stall};
      exp_fwd = {m_fwd(v1, int'(d_rs1)), m_fwd(v2, int'(d_rs2)),
                 m_fwd(e_rs1 != 0, int'(e_rs1)), m_fwd(e_rs2 != 0, int'(e_rs2))};
      exp_pend = '0;
      foreach (mpend[i]) exp_pend[i] = mpend[i];

      @(negedge clk);
      n_checks++;
      if ({stall_fetch, stall_decode, flush_decode, stall_execute, flush_execute,
           stall_memory, flush_memory, flush_writeback} !== exp_ctl) begin
        n_fail++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc,
          {stall_fetch, stall_decode, flush_decode, stall_execute, flush_execute,
           stall_memory, flush_memory, flush_writeback}, exp_ctl);
      end
      n_checks++;
      if ({fwd_rs1_d, fwd_rs2_d, fwd_rs1_e, fwd_rs2_e} !== exp_fwd) begin
        n_fail++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", cyc,
          {fwd_rs1_d, fwd_rs2_d, fwd_rs1_e, fwd_rs2_e}, exp_fwd);
      end
      n_checks++;
      if (sb_pending !== exp_pend || md_inflight !== 3'(mcnt)) begin
        n_fail++; $display("FAIL rnd_state cyc=%0d pending=%h exp=%h cnt=%0d exp=%0d",
          cyc, sb_pending, exp_pend, md_inflight, mcnt);
      end

      @(posedge clk);
      acc = e_md_issue && !dmem_stall;
      if (md_done) mpend[md_rd] = 0;
      if (acc && e_rd != 0) mpend[e_rd] = 1;
      mcnt = mcnt + (acc ? 1 : 0) - ((md_done && mcnt > 0) ? 1 : 0);
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_md_raw();
    test_md_full();
    test_back_to_back();
    test_load_waw();
    test_dmem_bj();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
